alu_writeback: RTL and testbench

- Consumer end of the ALU datapath for the core0 stack machine.
- Accepts ALU results plus the issuing instruction and retires them into the architectural top/second/carry registers.
- Those registers feed the ALU operand-select stage.
- Manages the stack depth, refills `second` from the data-stack memory after binary ops, and spills `second` to it on literal pushes.

---
 rtl/core0_pkg.sv | 15 +
 rtl/alu_writeback.sv | 148 ++++++++++++++
 tb/tb_alu_writeback.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/core0_pkg.sv
// Shared core0 definitions: instruction classes, carry-write bit
// and the writeback state encoding.
package core0_pkg;

    localparam logic [2:0] ICLASS_BINARY = 3'b001;
    localparam logic [2:0] ICLASS_UNARY  = 3'b010;
    localparam int         CARRY_WR_BIT  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SPILL = 2'd2
    } wb_state_e;

endpackage

// File: rtl/alu_writeback.sv
// Retires ALU results and literal pushes into top/second/carry,
// tracking stack depth and refilling/spilling second via the data stack.
module alu_writeback
    import core0_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_valid,
    input  logic [7:0]             instruction,
    input  logic [WORD_WIDTH-1:0]  alu_out,
    input  logic                   alu_oc,
    input  logic                   push_valid,
    input  logic [WORD_WIDTH-1:0]  push_data,
    output logic                   ready,
    output logic [WORD_WIDTH-1:0]  top,
    output logic [WORD_WIDTH-1:0]  second,
    output logic                   carry,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   underflow,
    output logic                   overflow,
    output logic                   ds_rd_req,
    input  logic                   ds_rd_valid,
    input  logic [WORD_WIDTH-1:0]  ds_rd_data,
    output logic                   ds_wr_req,
    input  logic                   ds_wr_ack,
    output logic [WORD_WIDTH-1:0]  ds_wr_data
);

    localparam logic [DEPTH_WIDTH-1:0] D_ZERO = '0;
    localparam logic [DEPTH_WIDTH-1:0] D_ONE  = DEPTH_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] D_TWO  = DEPTH_WIDTH'(2);
    localparam logic [DEPTH_WIDTH-1:0] D_MAX  = '1;

    wb_state_e              r_state;
    logic [WORD_WIDTH-1:0]  r_top;
    logic [WORD_WIDTH-1:0]  r_second;
    logic [WORD_WIDTH-1:0]  r_wr_data;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic                   r_carry;
    logic                   r_uf;
    logic                   r_of;
    logic                   r_rd_req;
    logic                   r_wr_req;

    logic       w_ready;
    logic       w_alu_acc;
    logic       w_push_acc;
    logic [2:0] w_class;
    logic       w_wr_carry;
    logic       w_unused;

    assign w_ready    = (r_state == IDLE);
    assign w_alu_acc  = alu_valid & w_ready;
    // ALU result wins; a simultaneous push is dropped, not queued
    assign w_push_acc = push_valid & w_ready & ~alu_valid;
    assign w_class    = instruction[7:5];
    assign w_wr_carry = instruction[CARRY_WR_BIT];
    assign w_unused   = ^instruction[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_top     <= '0;
            r_second  <= '0;
            r_wr_data <= '0;
            r_depth   <= '0;
            r_carry   <= 1'b0;
            r_uf      <= 1'b0;
            r_of      <= 1'b0;
            r_rd_req  <= 1'b0;
            r_wr_req  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_alu_acc) begin
                        if (w_class == ICLASS_BINARY) begin
                            if (r_depth < D_TWO) begin
                                r_uf <= 1'b1;
                            end else begin
                                r_top   <= alu_out;
                                r_depth <= r_depth - D_ONE;
                                if (w_wr_carry)
                                    r_carry <= alu_oc;
                                if (r_depth == D_TWO) begin
                                    r_second <= '0;
                                end else begin
                                    r_rd_req <= 1'b1;
                                    r_state  <= FILL;
                                end
                            end
                        end else if (w_class == ICLASS_UNARY) begin
                            if (r_depth == D_ZERO) begin
                                r_uf <= 1'b1;
                            end else begin
                                r_top <= alu_out;
                                if (w_wr_carry)
                                    r_carry <= alu_oc;
                            end
                        end
                    end else if (w_push_acc) begin
                        if (r_depth == D_MAX) begin
                            r_of <= 1'b1;
                        end else begin
                            r_top    <= push_data;
                            r_second <= r_top;
                            r_depth  <= r_depth + D_ONE;
                            // old second leaves the registers for memory
                            if (r_depth >= D_TWO) begin
                                r_wr_data <= r_second;
                                r_wr_req  <= 1'b1;
                                r_state   <= SPILL;
                            end
                        end
                    end
                end
                FILL: begin
                    if (ds_rd_valid) begin
                        r_second <= ds_rd_data;
                        r_rd_req <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                SPILL: begin
                    if (ds_wr_ack) begin
                        r_wr_req <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready      = w_ready;
    assign top        = r_top;
    assign second     = r_second;
    assign carry      = r_carry;
    assign depth      = r_depth;
    assign underflow  = r_uf;
    assign overflow   = r_of;
    assign ds_rd_req  = r_rd_req;
    assign ds_wr_req  = r_wr_req;
    assign ds_wr_data = r_wr_data;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed scoreboard bench for alu_writeback (DEPTH_WIDTH=2 so the
// overflow limit of 3 entries is reachable).
module tb_alu_writeback;

    localparam int WW = 32;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [7:0]    instruction;
    logic [WW-1:0] alu_out;
    logic          alu_oc;
    logic          push_valid;
    logic [WW-1:0] push_data;
    logic          ready;
    logic [WW-1:0] top;
    logic [WW-1:0] second;
    logic          carry;
    logic [DW-1:0] depth;
    logic          underflow;
    logic          overflow;
    logic          ds_rd_req;
    logic          ds_rd_valid;
    logic [WW-1:0] ds_rd_data;
    logic          ds_wr_req;
    logic          ds_wr_ack;
    logic [WW-1:0] ds_wr_data;

    alu_writeback #(.WORD_WIDTH(WW), .DEPTH_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .instruction(instruction),
        .alu_out(alu_out), .alu_oc(alu_oc),
        .push_valid(push_valid), .push_data(push_data),
        .ready(ready), .top(top), .second(second),
        .carry(carry), .depth(depth),
        .underflow(underflow), .overflow(overflow),
        .ds_rd_req(ds_rd_req), .ds_rd_valid(ds_rd_valid),
        .ds_rd_data(ds_rd_data), .ds_wr_req(ds_wr_req),
        .ds_wr_ack(ds_wr_ack), .ds_wr_data(ds_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [WW-1:0] t;
        logic [WW-1:0] s;
        logic          c;
        logic [DW-1:0] d;
        logic          uf;
        logic          of;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_exp = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_st(input logic [WW-1:0] t, input logic [WW-1:0] s,
                             input logic c, input logic [DW-1:0] d,
                             input logic uf, input logic of);
        exp_t e;
        e.id = n_exp;
        e.t = t; e.s = s; e.c = c; e.d = d; e.uf = uf; e.of = of;
        n_exp++;
        q.push_back(e);
    endtask

    // Monitor: compare once the DUT is back to accepting (result settled)
    always @(negedge clk) begin
        if (!reset && ready && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("state%0d", e.id),
                {top, second, carry, depth, underflow, overflow},
                {e.t, e.s, e.c, e.d, e.uf, e.of});
        end
    end

    task automatic do_push(input logic [WW-1:0] d);
        push_valid = 1'b1;
        push_data  = d;
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic do_alu(input logic [7:0] ins, input logic [WW-1:0] r,
                          input logic oc, input logic also_push);
        alu_valid   = 1'b1;
        instruction = ins;
        alu_out     = r;
        alu_oc      = oc;
        push_valid  = also_push;
        push_data   = 32'h77;
        @(posedge clk); #1;
        alu_valid  = 1'b0;
        push_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        ds_wr_ack = 1'b1;
        @(posedge clk); #1;
        ds_wr_ack = 1'b0;
    endtask

    task automatic pulse_rd(input logic [WW-1:0] d);
        ds_rd_valid = 1'b1;
        ds_rd_data  = d;
        @(posedge clk); #1;
        ds_rd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && q.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain", 128'(q.size()), 128'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        alu_valid = 0; instruction = 0; alu_out = 0; alu_oc = 0;
        push_valid = 0; push_data = 0;
        ds_rd_valid = 0; ds_rd_data = 0; ds_wr_ack = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset",
            {top, second, carry, depth, underflow, overflow,
             ds_rd_req, ds_wr_req, ds_wr_data, ready},
            {32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0,
             1'b0, 1'b0, 32'd0, 1'b1});

        do_push(5);  expect_st(5, 0, 0, 1, 0, 0);
        do_push(7);  expect_st(7, 5, 0, 2, 0, 0);
        chk("no_spill", 128'(ds_wr_req), 128'd0);
        do_alu(8'h50, 9, 1, 0);  expect_st(9, 5, 1, 2, 0, 0);
        drain();

        do_reset();
        do_push(1);  expect_st(1, 0, 0, 1, 0, 0);
        do_push(2);  expect_st(2, 1, 0, 2, 0, 0);
        do_push(3);  expect_st(3, 2, 0, 3, 0, 0);
        chk("spill_req", {ready, ds_wr_req, ds_wr_data}, {1'b0, 1'b1, 32'd1});
        repeat (2) @(posedge clk);
        #1 chk("spill_hold", {ready, ds_wr_req}, {1'b0, 1'b1});
        @(posedge clk); #1;
        pulse_ack();
        chk("spill_done", {ready, ds_wr_req}, {1'b1, 1'b0});
        drain();

        do_alu(8'h20, 5, 1, 0);  expect_st(5, 1, 0, 2, 0, 0);
        chk("fill_req", {ready, ds_rd_req}, {1'b0, 1'b1});
        repeat (2) @(posedge clk);
        #1 pulse_rd(1);
        chk("fill_done", {ready, ds_rd_req}, {1'b1, 1'b0});
        drain();

        do_alu(8'h30, 32'h11, 1, 0);  expect_st(32'h11, 0, 1, 1, 0, 0);
        chk("bin_d2_idle", {ready, ds_rd_req}, {1'b1, 1'b0});
        do_alu(8'h20, 32'h99, 0, 0);  expect_st(32'h11, 0, 1, 1, 1, 0);
        do_alu(8'h70, 32'h55, 0, 0);  expect_st(32'h11, 0, 1, 1, 1, 0);
        drain();

        do_reset();
        do_alu(8'h50, 32'h33, 1, 0);  expect_st(0, 0, 0, 0, 1, 0);
        do_push(4);                   expect_st(4, 0, 0, 1, 1, 0);
        do_alu(8'h40, 32'h22, 1, 1);  expect_st(32'h22, 0, 0, 1, 1, 0);
        do_push(8);                   expect_st(8, 32'h22, 0, 2, 1, 0);
        do_push(9);                   expect_st(9, 8, 0, 3, 1, 0);
        chk("spill_data", 128'(ds_wr_data), 128'h22);
        pulse_ack();
        drain();
        do_push(32'hA);               expect_st(9, 8, 0, 3, 1, 1);
        chk("ovf_no_spill", {ready, ds_wr_req}, {1'b1, 1'b0});
        pulse_rd(32'hDEAD);           expect_st(9, 8, 0, 3, 1, 1);
        drain();

        do_reset();
        do_push(1); do_push(2); do_push(3);
        pulse_ack();
        expect_st(3, 2, 0, 3, 0, 0);
        drain();
        do_alu(8'h20, 5, 0, 0);
        chk("fill_before_rst", {ready, ds_rd_req}, {1'b0, 1'b1});
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_in_fill",
               {top, second, carry, depth, underflow, overflow,
                ds_rd_req, ds_wr_req, ds_wr_data, ready},
               {32'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b0,
                1'b0, 1'b0, 32'd0, 1'b1});
        @(posedge clk); #1;
        reset = 1'b0;
        pulse_rd(32'hBEEF);           expect_st(0, 0, 0, 0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
